// File: rtl/axil_pkg.sv
// Shared cbus AXI-Lite definitions: response codes and the
// master bridge FSM state type.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WRESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } axil_mst_state_t;

endpackage

// File: rtl/axil_master_bridge.sv
// Single-beat valid/ready request port to AXI-Lite master, one
// transaction in flight. Ports: req_* in, resp_* out, cbus_* AXI-Lite.
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_we,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [1:0]              resp_code,
  output logic [ADDR_WIDTH-1:0]   cbus_awaddr,
  output logic                    cbus_awvalid,
  input  logic                    cbus_awready,
  output logic [DATA_WIDTH-1:0]   cbus_wdata,
  output logic [DATA_WIDTH/8-1:0] cbus_wstrb,
  output logic                    cbus_wvalid,
  input  logic                    cbus_wready,
  input  logic [1:0]              cbus_bresp,
  input  logic                    cbus_bvalid,
  output logic                    cbus_bready,
  output logic [ADDR_WIDTH-1:0]   cbus_araddr,
  output logic                    cbus_arvalid,
  input  logic                    cbus_arready,
  input  logic [DATA_WIDTH-1:0]   cbus_rdata,
  input  logic [1:0]              cbus_rresp,
  input  logic                    cbus_rvalid,
  output logic                    cbus_rready
);

  localparam int SW = DATA_WIDTH / 8;

  axil_mst_state_t state_q, state_d;

  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rwe_q, rwe_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            code_q, code_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;

  logic aw_hs, w_hs, aw_fin, w_fin;

  assign aw_hs  = awvalid_q && cbus_awready;
  assign w_hs   = wvalid_q && cbus_wready;
  // A channel is finished if it completed earlier or completes now.
  assign aw_fin = aw_done_q || aw_hs;
  assign w_fin  = w_done_q || w_hs;

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = rvalid_q;
  assign resp_we      = rwe_q;
  assign resp_rdata   = rdata_q;
  assign resp_code    = code_q;
  assign cbus_awaddr  = addr_q;
  assign cbus_araddr  = addr_q;
  assign cbus_awvalid = awvalid_q;
  assign cbus_wdata   = wdata_q;
  assign cbus_wstrb   = wstrb_q;
  assign cbus_wvalid  = wvalid_q;
  assign cbus_arvalid = arvalid_q;
  assign cbus_bready  = bready_q;
  assign cbus_rready  = rready_q;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    rvalid_d  = rvalid_q;
    rwe_d     = rwe_q;
    rdata_d   = rdata_q;
    code_d    = code_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs) wvalid_d = 1'b0;
        if (aw_fin && w_fin) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (cbus_bvalid) begin
          bready_d = 1'b0;
          rvalid_d = 1'b1;
          rwe_d    = 1'b1;
          rdata_d  = '0;
          code_d   = cbus_bresp;
          state_d  = RESP;
        end
      end
      RD_ADDR: begin
        if (cbus_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (cbus_rvalid) begin
          rready_d = 1'b0;
          rvalid_d = 1'b1;
          rwe_d    = 1'b0;
          rdata_d  = cbus_rdata;
          code_d   = cbus_rresp;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rwe_q     <= 1'b0;
      rdata_q   <= '0;
      code_q    <= RESP_OKAY;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      rvalid_q  <= rvalid_d;
      rwe_q     <= rwe_d;
      rdata_q   <= rdata_d;
      code_q    <= code_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  // Per-channel completion for the write address/data pair;
  // cleared while idle so each write starts fresh.
  always_comb begin
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (state_q == IDLE) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else if (state_q == WR) begin
      if (aw_hs) aw_done_d = 1'b1;
      if (w_hs) w_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axil_master_bridge.sv
// Bench for axil_master_bridge: stall-injecting AXI-Lite register
// slave, transaction scoreboard and per-cycle handshake rules.
module tb_axil_master_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_we;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_code;
  logic [1:0]  cbus_awaddr, cbus_araddr;
  logic        cbus_awvalid, cbus_awready;
  logic [31:0] cbus_wdata;
  logic [3:0]  cbus_wstrb;
  logic        cbus_wvalid, cbus_wready;
  logic [1:0]  cbus_bresp;
  logic        cbus_bvalid, cbus_bready;
  logic        cbus_arvalid, cbus_arready;
  logic [31:0] cbus_rdata;
  logic [1:0]  cbus_rresp;
  logic        cbus_rvalid, cbus_rready;

  always #5 clk = ~clk;

  axil_master_bridge #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we),
    .resp_rdata(resp_rdata), .resp_code(resp_code),
    .cbus_awaddr(cbus_awaddr), .cbus_awvalid(cbus_awvalid),
    .cbus_awready(cbus_awready), .cbus_wdata(cbus_wdata),
    .cbus_wstrb(cbus_wstrb), .cbus_wvalid(cbus_wvalid),
    .cbus_wready(cbus_wready), .cbus_bresp(cbus_bresp),
    .cbus_bvalid(cbus_bvalid), .cbus_bready(cbus_bready),
    .cbus_araddr(cbus_araddr), .cbus_arvalid(cbus_arvalid),
    .cbus_arready(cbus_arready), .cbus_rdata(cbus_rdata),
    .cbus_rresp(cbus_rresp), .cbus_rvalid(cbus_rvalid),
    .cbus_rready(cbus_rready)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // ---------------- slave model ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  b_code = 2'b00;
  logic [31:0] sregs [4];
  logic        have_aw, have_w, have_ar;
  logic [1:0]  s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;

  assign cbus_awready = cbus_awvalid && !have_aw && aw_wait >= aw_dly;
  assign cbus_wready  = cbus_wvalid && !have_w && w_wait >= w_dly;
  assign cbus_arready = cbus_arvalid && !have_ar && !cbus_rvalid &&
                        ar_wait >= ar_dly;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      have_aw <= 0; have_w <= 0; have_ar <= 0;
      aw_wait <= 0; w_wait <= 0; b_wait <= 0;
      ar_wait <= 0; r_wait <= 0;
      cbus_bvalid <= 0; cbus_bresp <= 0;
      cbus_rvalid <= 0; cbus_rresp <= 0; cbus_rdata <= 0;
    end else begin
      if (cbus_awready) begin
        have_aw <= 1; s_awaddr <= cbus_awaddr; aw_wait <= 0;
      end else if (cbus_awvalid && !have_aw) aw_wait <= aw_wait + 1;
      if (cbus_wready) begin
        have_w <= 1; s_wdata <= cbus_wdata;
        s_wstrb <= cbus_wstrb; w_wait <= 0;
      end else if (cbus_wvalid && !have_w) w_wait <= w_wait + 1;
      if (have_aw && have_w && !cbus_bvalid) begin
        if (b_wait >= b_dly) begin
          cbus_bvalid <= 1; cbus_bresp <= b_code;
          if (b_code == 2'b00)
            for (int i = 0; i < 4; i++)
              if (s_wstrb[i]) sregs[s_awaddr][8*i +: 8] <= s_wdata[8*i +: 8];
          have_aw <= 0; have_w <= 0; b_wait <= 0;
        end else b_wait <= b_wait + 1;
      end
      if (cbus_bvalid && cbus_bready) cbus_bvalid <= 0;
      if (cbus_arready) begin
        have_ar <= 1; s_araddr <= cbus_araddr; ar_wait <= 0;
      end else if (cbus_arvalid && !have_ar) ar_wait <= ar_wait + 1;
      if (have_ar && !cbus_rvalid) begin
        if (r_wait >= r_dly) begin
          cbus_rvalid <= 1; cbus_rdata <= sregs[s_araddr];
          cbus_rresp <= 2'b00; have_ar <= 0; r_wait <= 0;
        end else r_wait <= r_wait + 1;
      end
      if (cbus_rvalid && cbus_rready) cbus_rvalid <= 0;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic        we;
    logic [31:0] rdata;
    logic [1:0]  code;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] mdl [4];

  task automatic push_exp(input logic we, input logic [1:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.we = we;
    if (we) begin
      e.rdata = 0;
      e.code  = b_code;
      if (b_code == 2'b00)
        for (int i = 0; i < 4; i++)
          if (s[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
    end else begin
      e.rdata = mdl[a];
      e.code  = 2'b00;
    end
    exp_q.push_back(e);
  endtask

  // ---------------- per-cycle compare ----------------
  int          n_resp = 0;
  logic        last_we;
  logic [31:0] last_rdata;
  logic [1:0]  last_code;
  logic        p_aw = 0, p_awr = 0, p_w = 0, p_wr = 0, p_ar = 0, p_arr = 0;
  logic        p_rv = 0, p_rr = 0;
  logic [1:0]  p_awaddr, p_araddr;
  logic [35:0] p_wpay;
  logic [34:0] p_rpay;

  always @(negedge clk) begin
    if (!rstn) begin
      p_aw = 0; p_w = 0; p_ar = 0; p_rv = 0;
    end else begin
      if (p_aw) begin
        if (p_awr) chk("aw_drop", cbus_awvalid, 0);
        else begin
          chk("aw_hold", cbus_awvalid, 1);
          chk("aw_addr", cbus_awaddr, p_awaddr);
        end
      end
      if (p_w) begin
        if (p_wr) chk("w_drop", cbus_wvalid, 0);
        else begin
          chk("w_hold", cbus_wvalid, 1);
          chk("w_pay", {cbus_wstrb, cbus_wdata}, p_wpay);
        end
      end
      if (p_ar) begin
        if (p_arr) chk("ar_drop", cbus_arvalid, 0);
        else begin
          chk("ar_hold", cbus_arvalid, 1);
          chk("ar_addr", cbus_araddr, p_araddr);
        end
      end
      if (cbus_bready)
        chk("b_excl", {cbus_awvalid, cbus_wvalid, cbus_arvalid, cbus_rready}, 0);
      if (cbus_rready)
        chk("r_excl", {cbus_awvalid, cbus_wvalid, cbus_arvalid, cbus_bready}, 0);
      if (p_rv && !p_rr) begin
        chk("resp_hold", resp_valid, 1);
        chk("resp_stable", {resp_we, resp_code, resp_rdata}, p_rpay);
      end
      if (resp_valid) chk("busy_ready", req_ready, 0);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) chk("resp_extra", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_we", resp_we, e.we);
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_code", resp_code, e.code);
        end
        last_we = resp_we; last_rdata = resp_rdata; last_code = resp_code;
        n_resp++;
      end
      p_aw = cbus_awvalid; p_awr = cbus_awready; p_awaddr = cbus_awaddr;
      p_w = cbus_wvalid; p_wr = cbus_wready;
      p_wpay = {cbus_wstrb, cbus_wdata};
      p_ar = cbus_arvalid; p_arr = cbus_arready; p_araddr = cbus_araddr;
      p_rv = resp_valid; p_rr = resp_ready;
      p_rpay = {resp_we, resp_code, resp_rdata};
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic we, input logic [1:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input bit track);
    int n = 0;
    req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    req_valid = 1;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_timeout", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    if (track) push_exp(we, a, d, s);
  endtask

  task automatic wait_resp(input int n0);
    int n = 0;
    while (n_resp == n0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("resp_timeout", n_resp > n0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end want end");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n;
    for (int i = 0; i < 4; i++) begin
      sregs[i] = 0; mdl[i] = 0;
    end
    rstn = 0; req_valid = 0; req_we = 0; req_addr = 0;
    req_wdata = 0; req_wstrb = 0; resp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_out", {cbus_awvalid, cbus_wvalid, cbus_arvalid, cbus_bready,
                    cbus_rready, resp_valid, resp_we}, 0);
    chk("rst_pay", {resp_code, resp_rdata, cbus_awaddr, cbus_wdata, cbus_wstrb}, 0);
    rstn = 1;
    @(posedge clk); #1;

    // 1: write then read back
    n0 = n_resp; send(1, 1, 32'h5A, 4'hF, 1); wait_resp(n0);
    chk("t1_we", last_we, 1);
    chk("t1_wcode", last_code, 0);
    n0 = n_resp; send(0, 1, 0, 0, 1); wait_resp(n0);
    chk("t1_rdata", last_rdata, 32'h5A);
    chk("t1_rwe", last_we, 0);

    // 2: W accepted 3 cycles before AW
    aw_dly = 3;
    n0 = n_resp; send(1, 0, 32'h1234, 4'hF, 1);
    chk("t2_c0", {cbus_awvalid, cbus_wvalid, cbus_bready}, 3'b110);
    @(posedge clk); #1;
    chk("t2_c1", {cbus_awvalid, cbus_wvalid, cbus_bready}, 3'b100);
    @(posedge clk); #1; @(posedge clk); #1;
    chk("t2_c3", {cbus_awvalid, cbus_wvalid, cbus_bready}, 3'b100);
    @(posedge clk); #1;
    chk("t2_c4", {cbus_awvalid, cbus_wvalid, cbus_bready}, 3'b001);
    wait_resp(n0);
    repeat (3) @(posedge clk); #1;
    chk("t2_count", n_resp - n0, 1);
    chk("t2_code", last_code, 0);
    aw_dly = 0;

    // 3: slave error passed through, next read normal
    b_code = 2'b10;
    n0 = n_resp; send(1, 2, 32'hDEADBEEF, 4'hF, 1); wait_resp(n0);
    chk("t3_code", last_code, 2'b10);
    b_code = 2'b00;
    n0 = n_resp; send(0, 2, 0, 0, 1); wait_resp(n0);
    chk("t3_rdata", last_rdata, 0);
    chk("t3_rcode", last_code, 0);

    // 4: response back-pressure
    n0 = n_resp; send(1, 3, 32'hA5, 4'hF, 1); wait_resp(n0);
    resp_ready = 0;
    n0 = n_resp; send(0, 3, 0, 0, 1);
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("t4_valid", resp_valid, 1);
    req_we = 0; req_addr = 1; req_valid = 1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("t4_ready", req_ready, 0);
      chk("t4_ar", cbus_arvalid, 0);
      chk("t4_data", resp_rdata, 32'hA5);
    end
    resp_ready = 1;
    @(posedge clk); #1;
    chk("t4_rel", {req_ready, cbus_arvalid, resp_valid}, 3'b100);
    chk("t4_last", last_rdata, 32'hA5);
    push_exp(0, 1, 0, 0);
    @(posedge clk); #1;
    chk("t4_acc", cbus_arvalid, 1);
    req_valid = 0;
    wait_resp(n0 + 1);
    chk("t4_rd2", last_rdata, 32'h5A);

    // 5: reset while waiting for B
    b_dly = 20;
    send(1, 2, 32'h77, 4'hF, 0);
    n = 0;
    while (!cbus_bready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("t5_wresp", cbus_bready, 1);
    #1 rstn = 0;
    #1;
    chk("t5_rst", {cbus_awvalid, cbus_wvalid, cbus_arvalid, cbus_bready,
                   cbus_rready, resp_valid}, 0);
    @(posedge clk); #1;
    rstn = 1; b_dly = 0;
    chk("t5_ready", req_ready, 1);
    n0 = n_resp; send(1, 2, 32'h0BADF00D, 4'hF, 1); wait_resp(n0);
    chk("t5_code", last_code, 0);
    n0 = n_resp; send(0, 2, 0, 0, 1); wait_resp(n0);
    chk("t5_rd", last_rdata, 32'h0BADF00D);

    // 6: four writes then four reads with stalls
    w_dly = 1; b_dly = 1; ar_dly = 1; r_dly = 2;
    n0 = n_resp;
    for (int i = 0; i < 4; i++) begin
      n = n_resp;
      send(1, 2'(i), 32'hC0DE5A00 | i, (i == 0) ? 4'b0011 : 4'hF, 1);
      wait_resp(n);
    end
    for (int i = 0; i < 4; i++) begin
      n = n_resp;
      send(0, 2'(i), 0, 0, 1);
      wait_resp(n);
      if (i == 0) chk("t6_strb", last_rdata, 32'h00005A00);
    end
    chk("t6_last", last_rdata, 32'hC0DE5A03);
    repeat (3) @(posedge clk); #1;
    chk("t6_count", n_resp - n0, 8);
    chk("t6_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
